// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer and the processor datapath.
// The HALTED state only exists when CTRL_HALT_EN is defined.
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;

    // Instruction field positions; ry and imm overlap by design.
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RX_HI  = 12;
    localparam int RX_LO  = 10;
    localparam int RY_HI  = 9;
    localparam int RY_LO  = 7;
    localparam int IMM_HI = 9;
    localparam int IMM_LO = 0;

    // ALU class is every opcode with a clear MSB (0xx).
    localparam logic       OP_ALU_MSB = 1'b0;
    localparam logic [2:0] OP_OUT     = 3'b100;
    localparam logic [2:0] OP_LDI     = 3'b101;
    localparam logic [2:0] OP_HALT    = 3'b110;
    localparam logic [2:0] OP_REP     = 3'b111;

`ifdef CTRL_HALT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD_A, ST_EXEC, ST_WRITE, ST_HALTED} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD_A, ST_EXEC, ST_WRITE} state_t;
`endif

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [2:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Instruction handshake plus datapath control bundle between fetch, sequencer and datapath.
// The slave modport is the sequencer; the master modport is its environment.
interface proc_sequencer_if;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  reg_en;
    logic        a_en;
    logic        r_en;
    logic [2:0]  mux_sel;
    logic        imm_sel;
    logic        r_sel;
    logic [9:0]  imm;
    logic [2:0]  alu_op;
    logic        bus_en;
    logic        done;
    logic        halted;

    modport master (
        output instr_in, instr_valid,
        input  instr_ready, reg_en, a_en, r_en, mux_sel, imm_sel, r_sel,
               imm, alu_op, bus_en, done, halted
    );

    modport slave (
        input  instr_in, instr_valid,
        output instr_ready, reg_en, a_en, r_en, mux_sel, imm_sel, r_sel,
               imm, alu_op, bus_en, done, halted
    );
endinterface

// File: rtl/proc_sequencer_instr_decoder.sv
// Pure combinational split of an instruction word into its class flags and fields.
// Shared with the processor datapath.
module instr_decoder
    import proc_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output logic              is_alu,
    output logic              is_out,
    output logic              is_ldi,
    output logic              is_rep,
    output logic              is_halt,
    output logic [2:0]        op,
    output logic [2:0]        rx,
    output logic [2:0]        ry,
    output logic [9:0]        imm
);
    assign op      = ir[OP_HI:OP_LO];
    assign rx      = ir[RX_HI:RX_LO];
    assign ry      = ir[RY_HI:RY_LO];
    assign imm     = ir[IMM_HI:IMM_LO];

    assign is_alu  = (op[2] == OP_ALU_MSB);
    assign is_out  = (op == OP_OUT);
    assign is_ldi  = (op == OP_LDI);
    assign is_rep  = (op == OP_REP);
    assign is_halt = (op == OP_HALT);
endmodule

// File: rtl/proc_sequencer.sv
// Handshaked IDLE/LOAD_A/EXEC/WRITE sequencer driving the register/A/R/ULA datapath.
// Define CTRL_HALT_EN to make opcode 110 park the sequencer in HALTED until reset.
module proc_sequencer
    import proc_pkg::*;
(
    input logic             clock,
    input logic             resetn,
    proc_sequencer_if.slave bus
);
    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] ir;
    logic              accept;

    logic       is_alu, is_out, is_ldi, is_rep, is_halt;
    logic [2:0] op, rx, ry;
    logic [9:0] imm_f;

    instr_decoder u_decoder (
        .ir      (ir),
        .is_alu  (is_alu),
        .is_out  (is_out),
        .is_ldi  (is_ldi),
        .is_rep  (is_rep),
        .is_halt (is_halt),
        .op      (op),
        .rx      (rx),
        .ry      (ry),
        .imm     (imm_f)
    );

    assign accept = (state == ST_IDLE) && bus.instr_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (accept) ir <= bus.instr_in;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_LOAD_A;
`ifdef CTRL_HALT_EN
                // Halt is decided on the incoming word, so LOAD_A is never entered.
                if (accept && bus.instr_in[OP_HI:OP_LO] == OP_HALT) state_next = ST_HALTED;
`endif
            end
            ST_LOAD_A: state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WRITE;
            ST_WRITE:  state_next = ST_IDLE;
`ifdef CTRL_HALT_EN
            ST_HALTED: state_next = ST_HALTED;
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.reg_en      = '0;
        bus.a_en        = 1'b0;
        bus.r_en        = 1'b0;
        bus.mux_sel     = '0;
        bus.imm_sel     = 1'b0;
        bus.r_sel       = 1'b0;
        bus.bus_en      = 1'b0;
        bus.done        = 1'b0;
        bus.halted      = 1'b0;
        bus.imm         = imm_f;
        bus.alu_op      = op;

        case (state)
            ST_IDLE: bus.instr_ready = 1'b1;
            ST_LOAD_A: begin
                bus.mux_sel = rx;
                bus.a_en    = 1'b1;
            end
            ST_EXEC: begin
                if (is_alu) begin
                    bus.mux_sel = ry;
                    bus.r_en    = 1'b1;
                end else if (is_ldi) begin
                    bus.imm_sel = 1'b1;
                    bus.r_en    = 1'b1;
                end
            end
            ST_WRITE: begin
                bus.done = 1'b1;
                case (1'b1)
                    is_alu, is_ldi: begin
                        bus.r_sel  = 1'b1;
                        bus.reg_en = reg_onehot(rx);
                    end
                    is_rep: begin
                        bus.mux_sel = ry;
                        bus.reg_en  = reg_onehot(rx);
                    end
                    is_out: begin
                        bus.mux_sel = rx;
                        bus.bus_en  = 1'b1;
                    end
                    is_halt: ;
                    default: ;
                endcase
            end
`ifdef CTRL_HALT_EN
            ST_HALTED: begin
                bus.halted = 1'b1;
                bus.imm    = '0;
                bus.alu_op = '0;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed and random instructions against a cycle-table model.
// Exercises the CTRL_HALT_EN variant when that macro is defined at compile time.
module tb_proc_sequencer;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    proc_sequencer_if bus();

    proc_sequencer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       instr_ready;
        logic [7:0] reg_en;
        logic       a_en;
        logic       r_en;
        logic [2:0] mux_sel;
        logic       imm_sel;
        logic       r_sel;
        logic [9:0] imm;
        logic [2:0] alu_op;
        logic       bus_en;
        logic       done;
        logic       halted;
    } out_t;

    function automatic out_t sample_outs();
        out_t o;
        o.instr_ready = bus.instr_ready;
        o.reg_en      = bus.reg_en;
        o.a_en        = bus.a_en;
        o.r_en        = bus.r_en;
        o.mux_sel     = bus.mux_sel;
        o.imm_sel     = bus.imm_sel;
        o.r_sel       = bus.r_sel;
        o.imm         = bus.imm;
        o.alu_op      = bus.alu_op;
        o.bus_en      = bus.bus_en;
        o.done        = bus.done;
        o.halted      = bus.halted;
        return o;
    endfunction

    // Between instructions only the control strobes are meaningful.
    function automatic out_t ctrl_only(input out_t o);
        out_t r;
        r        = o;
        r.imm    = '0;
        r.alu_op = '0;
        return r;
    endfunction

    // Expected outputs N cycles after acceptance (0 = idle), straight from the opcode table.
    function automatic out_t model(input logic [15:0] instr, input int phase);
        out_t       o;
        logic [2:0] opc;
        int         rx_i, ry_i;
        o    = '0;
        opc  = instr[15:13];
        rx_i = int'(instr[12:10]);
        ry_i = int'(instr[9:7]);
        if (phase == 0) begin
            o.instr_ready = 1'b1;
            return o;
        end
        o.imm    = instr[9:0];
        o.alu_op = opc;
        if (phase == 1) begin
            o.a_en    = 1'b1;
            o.mux_sel = 3'(rx_i);
        end else if (phase == 2) begin
            if (opc < 3'd4) begin
                o.r_en    = 1'b1;
                o.mux_sel = 3'(ry_i);
            end else if (opc == 3'd5) begin
                o.imm_sel = 1'b1;
                o.r_en    = 1'b1;
            end
        end else begin
            o.done = 1'b1;
            if (opc < 3'd4 || opc == 3'd5) begin
                o.r_sel  = 1'b1;
                o.reg_en = 8'(2 ** rx_i);
            end else if (opc == 3'd7) begin
                o.mux_sel = 3'(ry_i);
                o.reg_en  = 8'(2 ** rx_i);
            end else if (opc == 3'd4) begin
                o.mux_sel = 3'(rx_i);
                o.bus_en  = 1'b1;
            end
        end
        return o;
    endfunction

    // Issues one instruction from an idle negedge and checks every cycle through the next idle.
    task automatic run_instr(input string name, input logic [15:0] instr);
        out_t got, exp;
        int   waited = 0;
        while (bus.instr_ready !== 1'b1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        if (bus.instr_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL %s_ready_timeout: instr_ready=%b required 1", name, bus.instr_ready);
            return;
        end
        bus.instr_in    = instr;
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        for (int ph = 1; ph <= 3; ph++) begin
            bus.instr_in = 16'($urandom);
            got = sample_outs();
            exp = model(instr, ph);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s_k+%0d (instr %h): got %h required %h", name, ph, instr, got, exp);
            end
            @(negedge clock);
        end
        got = ctrl_only(sample_outs());
        exp = model(instr, 0);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s_k+4_idle: got %h required %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        out_t got, exp;
        bus.instr_in    = 16'hA5A5;
        bus.instr_valid = 1'b1;
        resetn          = 1'b0;
        repeat (3) @(negedge clock);
        got = sample_outs();
        exp = model(16'h0, 0);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_held: got %h required %h", got, exp);
        end
        bus.instr_valid = 1'b0;
        resetn          = 1'b1;
        @(negedge clock);
        got = sample_outs();
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_released: got %h required %h", got, exp);
        end
    endtask

    task automatic test_directed();
        run_instr("ldi_r3", {3'b101, 3'd3, 10'h155});
        run_instr("alu010_r1_r6", {3'b010, 3'd1, 3'd6, 7'h00});
        run_instr("out_r7", {3'b100, 3'd7, 10'h2AA});
        run_instr("rep_r0_r5", {3'b111, 3'd0, 3'd5, 7'h11});
    endtask

    task automatic test_random();
        logic [2:0] opc;
        repeat (24) begin
            opc = 3'($urandom_range(0, 7));
`ifdef CTRL_HALT_EN
            if (opc == 3'b110) opc = 3'b111;
`endif
            run_instr("random", {opc, 13'($urandom)});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[4];
        out_t        got, exp;
        q[0] = {3'b001, 3'd2, 3'd4, 7'h05};
        q[1] = {3'b101, 3'd6, 10'h3FF};
        q[2] = {3'b100, 3'd5, 10'h000};
        q[3] = {3'b111, 3'd7, 3'd1, 7'h7F};
        for (int c = 0; c <= 16; c++) begin
            if (c == 16)          bus.instr_valid = 1'b0;
            else                  bus.instr_valid = 1'b1;
            if (c % 4 == 0 && c < 16) bus.instr_in = q[c / 4];
            else                      bus.instr_in = 16'($urandom);
            if (c % 4 == 0) begin
                got = ctrl_only(sample_outs());
                exp = model(16'h0, 0);
            end else begin
                got = sample_outs();
                exp = model(q[c / 4], c % 4);
            end
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL b2b_cycle%0d: got %h required %h", c, got, exp);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_exec();
        out_t        got, exp;
        logic [15:0] instr;
        instr = {3'b011, 3'd2, 3'd5, 7'h00};
        bus.instr_in    = instr;
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        @(negedge clock);
        got = sample_outs();
        exp = model(instr, 2);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL mid_exec_before_reset: got %h required %h", got, exp);
        end
        resetn = 1'b0;
        #1;
        got = sample_outs();
        exp = model(16'h0, 0);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL mid_exec_reset_async: got %h required %h", got, exp);
        end
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        resetn          = 1'b1;
        repeat (6) begin
            @(negedge clock);
            got = sample_outs();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL mid_exec_after_reset: got %h required %h", got, exp);
            end
        end
    endtask

    task automatic test_halt();
`ifdef CTRL_HALT_EN
        out_t got, exp;
        bus.instr_in    = {3'b110, 13'h1ABC};
        bus.instr_valid = 1'b1;
        @(negedge clock);
        exp        = '0;
        exp.halted = 1'b1;
        repeat (6) begin
            got = sample_outs();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL halted_hold: got %h required %h", got, exp);
            end
            @(negedge clock);
        end
        bus.instr_valid = 1'b0;
        resetn          = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        got = sample_outs();
        exp = model(16'h0, 0);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL halted_exit_reset: got %h required %h", got, exp);
        end
`else
        run_instr("nop", {3'b110, 13'h1ABC});
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        test_halt();
        run_instr("after_halt", {3'b000, 3'd4, 3'd3, 7'h00});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
